// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the four-digit multiplexed BCD display scanner.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;
    localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Select one BCD nibble of a packed four-digit value; index 0 is the units digit.
    function automatic logic [DIGIT_W-1:0] nibble_at(input logic [VALUE_W-1:0] v,
                                                     input logic [1:0]         idx);
        logic [DIGIT_W-1:0] r;
        r = v[3:0];
        case (idx)
            2'd0: r = v[3:0];
            2'd1: r = v[7:4];
            2'd2: r = v[11:8];
            2'd3: r = v[15:12];
            default: r = v[3:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/display_scan_scheduler_dwell_timer.sv
// Dwell prescaler: counts clock cycles while not cleared and flags the last cycle of each dwell.
module dwell_timer #(
    parameter int DWELL_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

    logic [CW-1:0] count;

    // With a single-cycle dwell the count is pinned at zero and tick is always high.
    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Multiplexed four-digit BCD display scanner with a one-deep pending buffer swapped in at frame boundaries.
// Build option LEADING_ZERO_BLANK_EN keeps leading-zero digits dark (the units digit is always lit).
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [VALUE_W-1:0] bcd_in,
    input  logic               bcd_valid,
    output logic               bcd_ready,
    output logic [SEL_W-1:0]   digit_sel,
    output logic [DIGIT_W-1:0] digit,
    output logic [3:0]         anode_n,
    output logic               frame_done,
    output state_e             state_dbg
);

    // Handshake: a value is transferred on any rising edge where bcd_valid and bcd_ready are both 1;
    // bcd_ready is low exactly while the pending buffer holds a value not yet shown.

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    state_e             state;
    logic [VALUE_W-1:0] disp_val;
    logic [VALUE_W-1:0] pend_val;
    logic               pend_full;

    logic               tick;
    logic               timer_clear;
    logic               scanning;
    logic               wrap;
    logic               accept;
    logic               move;
    logic [VALUE_W-1:0] disp_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [3:0]         anode_nxt;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    function automatic logic [3:0] slot_anode(input logic [VALUE_W-1:0] v,
                                              input logic [1:0]         idx);
`ifdef LEADING_ZERO_BLANK_EN
        logic [3:0] onehot;
        logic [3:0] has_sig;
        onehot     = 4'b0001 << idx;
        has_sig[3] = |v[15:12];
        has_sig[2] = has_sig[3] | (|v[11:8]);
        has_sig[1] = has_sig[2] | (|v[7:4]);
        has_sig[0] = 1'b1;
        return ~(onehot & has_sig);
`else
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        if (v == '0) begin
            onehot = onehot;
        end
        return ~onehot;
`endif
    endfunction

    assign bcd_ready   = ~pend_full;
    assign state_dbg   = state;
    assign timer_clear = (state != SCAN) || !en;
    assign scanning    = (state == SCAN) && en;
    assign wrap        = scanning && tick && (digit_sel == LAST_SEL);
    assign accept      = bcd_valid && !pend_full;
    // IDLE hands a pending value over right away; SCAN waits for the frame wrap.
    assign move        = pend_full && ((state == IDLE) || wrap);
    assign disp_nxt    = move ? pend_val : disp_val;

    always_comb begin
        sel_nxt = '0;
        if (scanning) begin
            if (tick) begin
                sel_nxt = (digit_sel == LAST_SEL) ? '0 : digit_sel + SEL_W'(1);
            end else begin
                sel_nxt = digit_sel;
            end
        end
    end

    // Next cycle is a SCAN cycle exactly when en is high, so that decides lit vs blank.
    assign anode_nxt = en ? slot_anode(disp_nxt, sel_nxt[1:0]) : 4'b1111;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            digit_sel  <= '0;
            digit      <= '0;
            anode_n    <= 4'b1111;
            frame_done <= 1'b0;
            disp_val   <= '0;
            pend_val   <= '0;
            pend_full  <= 1'b0;
        end else begin
            state      <= en ? SCAN : IDLE;
            digit_sel  <= sel_nxt;
            digit      <= nibble_at(disp_nxt, sel_nxt[1:0]);
            anode_n    <= anode_nxt;
            frame_done <= wrap;
            disp_val   <= disp_nxt;
            if (accept) begin
                pend_val  <= bcd_in;
                pend_full <= 1'b1;
            end else if (move) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: a DWELL=4 and a DWELL=1 instance share stimulus against a timeline model.
module tb_display_scan_scheduler;
    import display_pkg::*;

    localparam int DW_A = 4;
    localparam int DW_B = 1;
    localparam int W    = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;

    logic        a_ready, b_ready;
    logic [2:0]  a_sel, b_sel;
    logic [3:0]  a_digit, b_digit;
    logic [3:0]  a_anode, b_anode;
    logic        a_fd, b_fd;
    state_e      a_state, b_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    bit chk_on = 1'b0;

    display_scan_scheduler #(.DWELL_CYCLES(DW_A)) dut_a (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .bcd_ready(a_ready), .digit_sel(a_sel), .digit(a_digit), .anode_n(a_anode),
        .frame_done(a_fd), .state_dbg(a_state)
    );

    display_scan_scheduler #(.DWELL_CYCLES(DW_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
        .bcd_ready(b_ready), .digit_sel(b_sel), .digit(b_digit), .anode_n(b_anode),
        .frame_done(b_fd), .state_dbg(b_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timeline view: t counts cycles since the scan started; slot = (t / dwell) % 4,
    // and a frame ends whenever t reaches a multiple of 4*dwell.
    bit          m_scan[2];
    int          m_t[2];
    logic [15:0] m_disp[2];
    logic [15:0] m_pend[2];
    bit          m_pf[2];
    bit          m_fd[2];

    function automatic int dwell_of(input int k);
        return (k == 0) ? DW_A : DW_B;
    endfunction

    task automatic model_step(input int k);
        bit boundary;
        bit accept;
        bit move;
        if (rst) begin
            m_scan[k] = 1'b0; m_t[k] = 0; m_disp[k] = '0; m_pend[k] = '0;
            m_pf[k] = 1'b0; m_fd[k] = 1'b0;
        end else begin
            boundary = m_scan[k] && en && (((m_t[k] + 1) % (4 * dwell_of(k))) == 0);
            accept   = bcd_valid && !m_pf[k];
            move     = m_pf[k] && (!m_scan[k] || boundary);
            if (move) m_disp[k] = m_pend[k];
            if (accept) begin
                m_pend[k] = bcd_in;
                m_pf[k]   = 1'b1;
            end else if (move) begin
                m_pf[k] = 1'b0;
            end
            m_fd[k] = boundary;
            if (en) begin
                m_t[k]    = m_scan[k] ? m_t[k] + 1 : 0;
                m_scan[k] = 1'b1;
            end else begin
                m_t[k]    = 0;
                m_scan[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [13:0] model_word(input int k);
        int         slot;
        logic [3:0] an;
        logic [3:0] dg;
        slot = m_scan[k] ? (m_t[k] / dwell_of(k)) % 4 : 0;
        dg   = 4'((m_disp[k] >> (4 * slot)) & 16'h000F);
        an   = 4'hF;
        if (m_scan[k]) begin
            an = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot > 0 && (m_disp[k] >> (4 * slot)) == 16'h0000) an = 4'hF;
`endif
        end
        return {m_scan[k], !m_pf[k], m_fd[k], 3'(slot), dg, an};
    endfunction

    always @(posedge clk) begin
        if (rst) chk_on = 1'b1;
        for (int k = 0; k < 2; k++) model_step(k);
        if (chk_on) exp_q.push_back({model_word(0), model_word(1)});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] want;
        logic [W-1:0] got;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {a_state == SCAN, a_ready, a_fd, a_sel, a_digit, a_anode,
                    b_state == SCAN, b_ready, b_fd, b_sel, b_digit, b_anode};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL model_cmp @%0t: got A=%h B=%h want A=%h B=%h",
                         $time, got[27:14], got[13:0], want[27:14], want[13:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_anode"}, 16'(a_anode), 16'hF);
        chk({tag, "_sel"}, 16'(a_sel), 16'h0);
        chk({tag, "_digit"}, 16'(a_digit), 16'h0);
        chk({tag, "_ready"}, 16'(a_ready), 16'h1);
        chk({tag, "_fd"}, 16'(a_fd), 16'h0);
        chk({tag, "_state"}, 16'(a_state == SCAN), 16'h0);
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [3:0] an_seq[4];
    logic [3:0] dig_1234[4];

    initial begin
        an_seq   = '{4'hE, 4'hD, 4'hB, 4'h7};
        dig_1234 = '{4'h4, 4'h3, 4'h2, 4'h1};

        step(); step();
        rst = 1'b0;
        chk_reset_values("reset");

        // Scenario 1: load in IDLE, then scan one full frame.
        bcd_in = 16'h1234; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        chk("s1_ready_after_accept", 16'(a_ready), 16'h0);
        step();
        chk("s1_ready_after_move", 16'(a_ready), 16'h1);
        chk("s1_idle_digit", 16'(a_digit), 16'h4);
        chk("s1_idle_anode", 16'(a_anode), 16'hF);
        en = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            chk("s1_digit", 16'(a_digit), 16'(dig_1234[k / 4]));
            chk("s1_anode", 16'(a_anode), 16'(an_seq[k / 4]));
            chk("s1_sel", 16'(a_sel), 16'(k / 4));
            chk("s1_fd_low", 16'(a_fd), 16'h0);
            chk("s1_dwell1_sel", 16'(b_sel), 16'(k % 4));
            step();
        end
        chk("s1_frame_done", 16'(a_fd), 16'h1);
        chk("s1_wrap_sel", 16'(a_sel), 16'h0);
        step();
        chk("s1_fd_one_cycle", 16'(a_fd), 16'h0);

        // Scenarios 2/3: load mid-frame, then offer another value while pending is full.
        bcd_in = 16'h5678; bcd_valid = 1'b1;
        step();
        bcd_in = 16'h9870;
        chk("s2_ready_low", 16'(a_ready), 16'h0);
        for (int k = 19; k <= 31; k++) begin
            step();
            chk("s3_ready_held", 16'(a_ready), 16'h0);
        end
        chk("s2_old_value_last_slot", 16'(a_digit), 16'h1);
        chk("s2_last_sel", 16'(a_sel), 16'h3);
        step();
        chk("s2_boundary_fd", 16'(a_fd), 16'h1);
        chk("s2_new_value_digit", 16'(a_digit), 16'h8);
        chk("s3_ready_after_boundary", 16'(a_ready), 16'h1);
        step();
        chk("s3_accepted_after_boundary", 16'(a_ready), 16'h0);
        chk("s3_display_unchanged", 16'(a_digit), 16'h8);
        bcd_valid = 1'b0;

        // Scenario 4: drop en while slot 2 is lit.
        repeat (8) step();
        chk("s4_sel_before_drop", 16'(a_sel), 16'h2);
        en = 1'b0;
        step();
        chk("s4_blank", 16'(a_anode), 16'hF);
        chk("s4_sel_cleared", 16'(a_sel), 16'h0);
        chk("s4_state_idle", 16'(a_state == SCAN), 16'h0);
        chk("s4_digit_old", 16'(a_digit), 16'h8);
        step();
        chk("s4_idle_move", 16'(a_digit), 16'h0);
        en = 1'b1;
        step();
        chk("s4_restart_sel", 16'(a_sel), 16'h0);
        chk("s4_restart_anode", 16'(a_anode), 16'hE);

        // Scenario 5: reset mid-dwell with a pending value.
        step(); step();
        bcd_in = 16'h1111; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        chk("s5_pending_full", 16'(a_ready), 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values("s5_reset");
        for (int k = 0; k < 16; k++) begin
            step();
            chk("s5_pending_discarded", 16'(a_digit), 16'h0);
            chk("s5_anode", 16'(a_anode), 16'(an_seq[k / 4]));
        end

        // Random phase: model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 499) == 0);
            en        = ($urandom_range(0, 39) != 0);
            bcd_valid = ($urandom_range(0, 3) == 0);
            bcd_in    = rand_bcd();
            step();
        end
        rst = 1'b0; bcd_valid = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
        // Scenario 6: leading-zero blanking.
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0;
        bcd_in = 16'h0042; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        step();
        en = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            chk("s6_0042_anode", 16'(a_anode), (k < 8) ? 16'(an_seq[k / 4]) : 16'hF);
            step();
        end
        en = 1'b0;
        step();
        bcd_in = 16'h0000; bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        step();
        en = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            chk("s6_0000_anode", 16'(a_anode), (k < 4) ? 16'hE : 16'hF);
            chk("s6_0000_digit", 16'(a_digit), 16'h0);
            step();
        end
`endif

        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_scheduler.md
DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

Interface
REQ-001 The module SHALL have parameter DWELL_CYCLES, default 100000, clock cycles each digit is lit (legal range >= 1).
REQ-002 The module SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port en, input, 1 bit, scan enable.
REQ-005 The module SHALL have port bcd_in, input, 16 bits, four BCD digits with the units digit in bits [3:0].
REQ-006 The module SHALL have port bcd_valid, input, 1 bit, meaning bcd_in carries a new value.
REQ-007 The module SHALL have port bcd_ready, output, 1 bit, meaning the pending buffer can accept a value.
REQ-008 The module SHALL have port digit_sel, output, 3 bits, active digit index 0..3, the digit-select code for the BCD digit mux.
REQ-009 The module SHALL have port digit, output, 4 bits, BCD nibble for the active digit.
REQ-010 The module SHALL have port anode_n, output, 4 bits, active-low digit enables, where bit i drives digit i.
REQ-011 The module SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of each full scan.

Function
REQ-012 The FSM SHALL have states IDLE and SCAN.
REQ-013 In IDLE, anode_n SHALL be 4'b1111; with en=1 the FSM SHALL enter SCAN at the next edge with digit_sel=0 and the dwell count at 0.
REQ-014 In SCAN, the dwell counter SHALL increment each cycle; on reaching DWELL_CYCLES-1 it SHALL wrap to 0 and digit_sel SHALL advance, 3 wrapping to 0.
REQ-015 The wrap from 3 to 0 SHALL assert frame_done for exactly that one cycle.
REQ-016 digit, anode_n and digit_sel SHALL be registered and update on the same edge; in SCAN, anode_n = ~(4'b0001 << digit_sel).
REQ-017 digit_sel SHALL never take values 4..7.
REQ-018 In SCAN, en=0 SHALL force IDLE at the next edge, clear the dwell counter and digit_sel, and blank anode_n.
REQ-019 bcd_ready SHALL equal NOT pending_full; a transfer occurs when bcd_valid and bcd_ready are both 1 at an edge, and it sets pending_full.
REQ-020 In SCAN, the pending value SHALL move into the display register only at the frame_done edge, clearing pending_full, so no frame mixes two values.
REQ-021 In IDLE, a pending value SHALL move into the display register on the edge after acceptance.
REQ-022 An accept and a frame-boundary move on the same edge are not possible, because ready is 0 while pending is full; a value accepted on a boundary edge when pending is empty SHALL be shown from the following frame.
REQ-023 With DWELL_CYCLES=1, digit_sel SHALL advance every cycle.

Reset
REQ-024 Reset SHALL set: state IDLE, dwell counter 0, digit_sel 0, digit 0, anode_n 4'b1111, display register 0, pending_full 0, bcd_ready 1, frame_done 0.
REQ-025 Reset asserted mid-frame SHALL take priority over all other events and discard any pending value.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined, during slot i (i>0) anode_n[i] SHALL stay 1 when display digits i..3 are all zero; digit 0 is always lit.
REQ-027 Without LEADING_ZERO_BLANK_EN, all four digits SHALL be lit in turn regardless of value.

Structure
REQ-028 Package display_pkg SHALL hold the state enum, NUM_DIGITS=4 and DIGIT_W=4.
REQ-029 The dwell prescaler SHALL be the sub-module dwell_timer (inputs clk, rst, clear; output tick at DWELL_CYCLES-1).

Verification
REQ-030 Scenario 1: DWELL_CYCLES=4, en=1, load 16'h1234 in IDLE -> digit sequence 4,3,2,1, each held 4 cycles, anode_n 1110,1101,1011,0111, frame_done every 16 cycles.
REQ-031 Scenario 2: load 16'h5678 mid-frame while 16'h1234 is displayed -> the remaining digits of the current frame show 1234; 5678 starts at digit_sel=0 after frame_done; bcd_ready is 0 until then.
REQ-032 Scenario 3: second bcd_valid while pending is full -> not accepted and ready is 0; accepted on the edge after the frame boundary.
REQ-033 Scenario 4: en dropped at digit_sel=2 -> next cycle anode_n=1111 and digit_sel=0; on re-enable the scan restarts at digit 0.
REQ-034 Scenario 5: rst pulsed mid-dwell with a value pending -> all REQ-024 values hold next cycle, and the pending value is never displayed.
REQ-035 Scenario 6: LEADING_ZERO_BLANK_EN, value 16'h0042 -> digits 2 and 3 stay dark; value 16'h0000 -> only digit 0 is lit, showing 0.
